tcm_signature_dumper: RTL and testbench

// - Read-side counterpart of the TCM image preload. On an ecall-commit trigger it latches the x3

---
 rtl/tcm_signature_dumper.sv | 142 ++++++++++++++
 tb/tb_tcm_signature_dumper.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_signature_dumper.sv
// tcm_signature_dumper
//   On an ecall-commit trigger, latches x3 (and pass = x3 == 1). It then reads
//   DTCM bank A/B rows 0..ROWS-1 and streams every byte out little-endian on a
//   valid/ready byte port: 8 x3 header bytes, then per row A[7:0]..A[63:56],
//   B[7:0]..B[63:56]. This matches the image byte order BASE + row*16 + k.
//
// Ports
//   CLK, RSTn        clock (rising edge), asynchronous active-low reset
//   trig_valid/x3    trigger pulse and x3 value; sampled only in IDLE or DONE
//   dtcm_rd_en/addr  DTCM A+B read strobe and row address
//   dtcm_A/B_rdata   bank data, valid the cycle after dtcm_rd_en
//   byte_valid/data/last/ready  output byte stream
//   busy, done, pass dump in progress, dump complete (sticky), latched x3 == 1
//   state_dbg        current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where byte_valid & byte_ready.
// byte_valid is a function of state only, so byte_data/byte_last hold while
// stalled and byte_valid never drops without acceptance. byte_ready only gates
// the state advance.
module tcm_signature_dumper #(
  parameter int AW   = 10,
  parameter int ROWS = 1000
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          trig_valid,
  input  logic [63:0]   trig_x3,
  output logic          dtcm_rd_en,
  output logic [AW-1:0] dtcm_rd_addr,
  input  logic [63:0]   dtcm_A_rdata,
  input  logic [63:0]   dtcm_B_rdata,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_last,
  input  logic          byte_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t         state, state_n;
  logic [127:0]   shreg, shreg_n;
  logic [AW-1:0]  row, row_n;
  logic [3:0]     byte_idx, byte_idx_n;
  logic           pass_q, pass_n;
  logic           accept;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      shreg    <= '0;
      row      <= '0;
      byte_idx <= '0;
      pass_q   <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      row      <= row_n;
      byte_idx <= byte_idx_n;
      pass_q   <= pass_n;
    end
  end

  assign accept = byte_valid & byte_ready;

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    row_n      = row;
    byte_idx_n = byte_idx;
    pass_n     = pass_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (trig_valid) begin
          state_n    = S_HDR;
          shreg_n    = {64'd0, trig_x3};
          pass_n     = (trig_x3 == 64'd1);
          row_n      = '0;
          byte_idx_n = '0;
        end
      end
      S_HDR: begin
        if (accept) begin
          shreg_n    = shreg >> 8;
          byte_idx_n = byte_idx + 4'd1;
          if (byte_idx == 4'd7) state_n = S_RD;
        end
      end
      S_RD: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // Read data from the RD cycle is valid now; B occupies the upper half
        // so that bank A bytes go out first.
        shreg_n    = {dtcm_B_rdata, dtcm_A_rdata};
        byte_idx_n = '0;
        state_n    = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          shreg_n    = shreg >> 8;
          byte_idx_n = byte_idx + 4'd1;
          if (byte_idx == 4'd15) begin
            if (row == LAST_ROW) begin
              state_n = S_DONE;
            end else begin
              row_n   = row + 1'b1;
              state_n = S_RD;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    byte_valid   = (state == S_HDR) || (state == S_SEND);
    byte_data    = byte_valid ? shreg[7:0] : 8'd0;
    byte_last    = (state == S_SEND) && (row == LAST_ROW) && (byte_idx == 4'd15);
    dtcm_rd_en   = (state == S_RD);
    dtcm_rd_addr = (state == S_RD) ? row : '0;
    busy         = (state == S_HDR) || (state == S_RD) ||
                   (state == S_WAIT) || (state == S_SEND);
    done         = (state == S_DONE);
    pass         = pass_q;
    state_dbg    = state;
  end

endmodule

// File: tb/tb_tcm_signature_dumper.sv
module tb_tcm_signature_dumper;

  localparam int AW     = 4;
  localparam int ROWS   = 2;
  localparam int BUDGET = 2000;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          trig_valid = 1'b0;
  logic [63:0]   trig_x3 = '0;
  logic          dtcm_rd_en;
  logic [AW-1:0] dtcm_rd_addr;
  logic [63:0]   dtcm_A_rdata = '0;
  logic [63:0]   dtcm_B_rdata = '0;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          pass;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {byte_last, byte_data}.
  logic [8:0] exp_q[$];

  logic [63:0] mem_a [0:(1<<AW)-1];
  logic [63:0] mem_b [0:(1<<AW)-1];
  int rd_cnt = 0;

  tcm_signature_dumper #(.AW(AW), .ROWS(ROWS)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .trig_valid(trig_valid), .trig_x3(trig_x3),
    .dtcm_rd_en(dtcm_rd_en), .dtcm_rd_addr(dtcm_rd_addr),
    .dtcm_A_rdata(dtcm_A_rdata), .dtcm_B_rdata(dtcm_B_rdata),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready),
    .busy(busy), .done(done), .pass(pass), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // DTCM model: synchronous read, one cycle latency
  always @(posedge CLK) begin
    if (dtcm_rd_en) begin
      dtcm_A_rdata <= mem_a[dtcm_rd_addr];
      dtcm_B_rdata <= mem_b[dtcm_rd_addr];
      rd_cnt       <= rd_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [63:0] x3);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, x3[8*k +: 8]});
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < 16; k++) begin
        w = (k < 8) ? mem_a[r] : mem_b[r];
        exp_q.push_back({(r == ROWS-1) && (k == 15), w[8*(k%8) +: 8]});
      end
    end
  endtask

  // Pulses trigger for one edge; returns at the negedge of the first cycle after it.
  task automatic start(input logic [63:0] x3);
    @(negedge CLK);
    trig_valid = 1'b1;
    trig_x3    = x3;
    byte_ready = 1'b1;
    push_expected(x3);
    @(negedge CLK);
    trig_valid = 1'b0;
  endtask

  // Runs cycles starting at the current cycle (cycle 1 after trigger), checking
  // every accepted byte and stall stability. done_edge = edge count to done.
  task automatic collect(input int pct, input int trig_at, input int stop_at,
                         output int done_edge);
    logic       stalled = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_last = 1'b0;
    logic [8:0] e;
    bit         finished = 0;
    done_edge = -1;
    for (int n = 1; n <= BUDGET && !finished; n++) begin
      if (stop_at != 0 && n == stop_at) begin
        finished = 1;
      end else begin
        byte_ready = ($urandom_range(0, 99) < pct);
        trig_valid = (n == trig_at);
        trig_x3    = 64'd7;
        if (stalled) begin
          checks++;
          if (byte_valid !== 1'b1 || byte_data !== held_data || byte_last !== held_last) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     byte_valid, byte_data, byte_last, held_data, held_last);
          end
        end
        if (byte_valid && byte_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got data=%h last=%b, required no byte", byte_data, byte_last);
          end else begin
            e = exp_q.pop_front();
            if ({byte_last, byte_data} !== e) begin
              errors++;
              $display("FAIL byte_stream: got last=%b data=%h, required last=%b data=%h",
                       byte_last, byte_data, e[8], e[7:0]);
            end
          end
        end
        stalled   = byte_valid && !byte_ready;
        held_data = byte_data;
        held_last = byte_last;
        if (done) begin
          done_edge = n - 1;
          finished  = 1;
        end else begin
          @(negedge CLK);
        end
      end
    end
    trig_valid = 1'b0;
    byte_ready = 1'b1;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen within %0d cycles, required done=1", BUDGET);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes missing, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, done, pass, byte_valid, byte_last, dtcm_rd_en} !== 6'b0 ||
        byte_data !== 8'd0 || dtcm_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b valid=%b data=%h last=%b rd_en=%b addr=%h, required all 0",
               busy, done, pass, byte_valid, byte_data, byte_last, dtcm_rd_en, dtcm_rd_addr);
    end
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, done, byte_valid} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b valid=%b, required 000", busy, done, byte_valid);
    end
  endtask

  task automatic test_pass_dump;
    int de;
    int rd0;
    rd0 = rd_cnt;
    start(64'd1);
    checks++;
    if (busy !== 1'b1 || byte_valid !== 1'b1 || byte_data !== 8'h01) begin
      errors++;
      $display("FAIL first_header: busy=%b valid=%b data=%h, required 1 1 01", busy, byte_valid, byte_data);
    end
    collect(100, 0, 0, de);
    checks++;
    if (de !== 8 + ROWS*18) begin
      errors++;
      $display("FAIL done_latency: %0d edges, required %0d", de, 8 + ROWS*18);
    end
    checks++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pass_one: pass=%b busy=%b, required pass=1 busy=0", pass, busy);
    end
    checks++;
    if (rd_cnt - rd0 != ROWS) begin
      errors++;
      $display("FAIL rd_count: %0d reads, required %0d", rd_cnt - rd0, ROWS);
    end
    check_drained("pass_dump");
  endtask

  task automatic test_fail_value;
    int de;
    start(64'h2);
    checks++;
    if (pass !== 1'b0) begin
      errors++;
      $display("FAIL pass_two: pass=%b, required 0", pass);
    end
    collect(100, 0, 0, de);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL fail_dump_done: done=%b pass=%b, required done=1 pass=0", done, pass);
    end
    check_drained("fail_value");
  endtask

  task automatic test_upper_bits;
    int de;
    // x3 == 1 only in the low bits must not pass
    start(64'h8000_0000_0000_0001);
    collect(100, 0, 0, de);
    checks++;
    if (pass !== 1'b0) begin
      errors++;
      $display("FAIL pass_full_width: pass=%b, required 0", pass);
    end
    check_drained("upper_bits");
  endtask

  task automatic test_random_ready;
    int de;
    start(64'd1);
    collect(50, 0, 0, de);
    checks++;
    if (de < 8 + ROWS*18) begin
      errors++;
      $display("FAIL stalled_latency: %0d edges, required >= %0d", de, 8 + ROWS*18);
    end
    check_drained("random_ready");
  endtask

  task automatic test_trigger_busy;
    int de;
    start(64'd1);
    collect(100, 15, 0, de);
    checks++;
    if (pass !== 1'b1 || de !== 8 + ROWS*18) begin
      errors++;
      $display("FAIL busy_trigger: pass=%b edges=%0d, required pass=1 edges=%0d", pass, de, 8 + ROWS*18);
    end
    check_drained("trigger_busy");
  endtask

  task automatic test_back_to_back;
    int de;
    int rd0;
    rd0 = rd_cnt;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky: done=%b, required 1", done);
    end
    start(64'h0123_4567_89ab_cdef);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL retrigger: done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    collect(100, 0, 0, de);
    checks++;
    if (rd_cnt - rd0 != ROWS) begin
      errors++;
      $display("FAIL retrigger_rd_count: %0d reads, required %0d", rd_cnt - rd0, ROWS);
    end
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid_dump;
    int de;
    start(64'd1);
    collect(100, 0, 30, de);   // cycle 30 is inside SEND of row 1
    checks++;
    if (byte_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_send: valid=%b busy=%b, required 1 1", byte_valid, busy);
    end
    #2 RSTn = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, byte_valid, byte_last, dtcm_rd_en} !== 6'b0 || byte_data !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b pass=%b valid=%b data=%h last=%b rd_en=%b, required all 0",
               busy, done, pass, byte_valid, byte_data, byte_last, dtcm_rd_en);
    end
    exp_q.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    start(64'h5);
    collect(100, 0, 0, de);
    checks++;
    if (de !== 8 + ROWS*18 || pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_reset: edges=%0d pass=%b, required edges=%0d pass=0", de, pass, 8 + ROWS*18);
    end
    check_drained("reset_mid_dump");
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
    test_reset();
    test_pass_dump();
    test_fail_value();
    test_upper_bits();
    test_random_ready();
    test_trigger_busy();
    test_back_to_back();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
